instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/pc_reg.sv | 48 ++++
 rtl/instr_fetch.sv | 166 ++++++++++++++++
 tb/tb_instr_fetch.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e    : fetch FSM states
//   PC_INC           : PC advance per fetched word
//   DEFAULT_RESET_PC : default reset value of the program counter
//   align_word()     : clears the byte-offset bits of an address
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } fetch_state_e;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: reset to RESET_PC, load, or advance by PC_INC.
// Load has priority over increment; increment wraps modulo 2^32.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   load_i      : load pc from load_val_i
//   load_val_i  : value for load
//   inc_i       : advance pc by PC_INC
//   pc_o        : current program counter
module pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    input  logic        inc_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Next PC selection
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + PC_INC;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues a word read at pc, captures the returned
// instruction, pulses write_ir/fetch_done and advances pc by 4.
// A flushed fetch whose request was already accepted drains the pending
// response before returning to IDLE.
// Optional feature: define FETCH_MISALIGN_CHK_EN to reject fetches from a
// non word-aligned pc with a one-cycle fetch_fault pulse.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   fetch_req, pc_load,
//   pc_next, flush      : control requests (acted on in IDLE, flush in REQ/WAIT)
//   mem_req, mem_addr,
//   mem_ready           : memory request handshake
//   mem_rvalid,
//   mem_rdata           : memory read response
//   instruction,
//   write_ir, fetch_done: fetched word and completion pulses
//   pc, busy,
//   fetch_fault         : status
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic        pc_load,
    input  logic [31:0] pc_next,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instruction,
    output logic        write_ir,
    output logic        fetch_done,
    output logic [31:0] pc,
    output logic        busy,
    output logic        fetch_fault
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  instr_q;
    logic [31:0]  instr_d;
    logic         fault_q;
    logic         fault_d;
    logic         pc_load_s;
    logic         pc_inc_s;
    logic         mem_req_s;
    logic [31:0]  pc_s;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .load_i     (pc_load_s),
        .load_val_i (pc_next),
        .inc_i      (pc_inc_s),
        .pc_o       (pc_s)
    );

    // Next-state, data capture and request decode
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        fault_d   = 1'b0;
        pc_load_s = 1'b0;
        pc_inc_s  = 1'b0;
        mem_req_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A load wins over a simultaneous fetch request
                if (pc_load) begin
                    pc_load_s = 1'b1;
                end else if (fetch_req) begin
`ifdef FETCH_MISALIGN_CHK_EN
                    if (pc_s[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
`else
                    state_d = ST_REQ;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                mem_req_s = 1'b1;
                if (flush) begin
                    // Once accepted, the response must still be drained
                    if (mem_ready) begin
                        state_d = ST_DRAIN;
                    end else begin
                        mem_req_s = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end else if (mem_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        instr_d = mem_rdata;
                        state_d = ST_DONE;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                pc_inc_s = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, instruction and fault registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            instr_q <= 32'h0000_0000;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    // mem_req must drop combinationally on a flush in REQ, so it is not registered
    assign mem_req     = mem_req_s;
    assign mem_addr    = mem_req_s ? align_word(pc_s) : 32'h0000_0000;
    assign instruction = instr_q;
    assign write_ir    = (state_q == ST_DONE);
    assign fetch_done  = (state_q == ST_DONE);
    assign pc          = pc_s;
    assign busy        = (state_q != ST_IDLE);
`ifdef FETCH_MISALIGN_CHK_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic        pc_load;
    logic [31:0] pc_next;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] instruction;
    logic        write_ir;
    logic        fetch_done;
    logic [31:0] pc;
    logic        busy;
    logic        fetch_fault;

    int vectors = 0;
    int errs    = 0;
    int hs      = 0;
    int hs_base = 0;

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .pc_load     (pc_load),
        .pc_next     (pc_next),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instruction (instruction),
        .write_ir    (write_ir),
        .fetch_done  (fetch_done),
        .pc          (pc),
        .busy        (busy),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted memory requests
    always @(posedge clk) begin
        if (!reset && mem_req && mem_ready) hs++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; pc_next = 32'h0;
        flush = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        tick(); tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_write_ir", {31'd0, write_ir}, 32'd0);
        chk("rst_fetch_done", {31'd0, fetch_done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        reset = 1'b0;

        // Basic fetch with zero-wait memory
        fetch_req = 1'b1; mem_ready = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("f1_mem_req", {31'd0, mem_req}, 32'd1);
        chk("f1_mem_addr", mem_addr, 32'h0);
        chk("f1_busy", {31'd0, busy}, 32'd1);
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
        chk("f1_wait_no_req", {31'd0, mem_req}, 32'd0);
        chk("f1_wait_no_wir", {31'd0, write_ir}, 32'd0);
        tick();
        mem_rvalid = 1'b0;
        chk("f1_write_ir", {31'd0, write_ir}, 32'd1);
        chk("f1_fetch_done", {31'd0, fetch_done}, 32'd1);
        chk("f1_instr", instruction, 32'h0050_0093);
        chk("f1_pc_before_inc", pc, 32'h0);
        tick();
        chk("f1_wir_pulse_end", {31'd0, write_ir}, 32'd0);
        chk("f1_done_pulse_end", {31'd0, fetch_done}, 32'd0);
        chk("f1_pc", pc, 32'h4);
        chk("f1_idle", {31'd0, busy}, 32'd0);

        // Memory stalls three cycles before accepting
        hs_base = hs;
        fetch_req = 1'b1; mem_ready = 1'b0;
        tick();
        fetch_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_mem_req", {31'd0, mem_req}, 32'd1);
            chk("stall_mem_addr", mem_addr, 32'h4);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("stall_mem_req4", {31'd0, mem_req}, 32'd1);
        chk("stall_mem_addr4", mem_addr, 32'h4);
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        chk("stall_req_dropped", {31'd0, mem_req}, 32'd0);
        tick();
        mem_rvalid = 1'b0;
        chk("stall_write_ir", {31'd0, write_ir}, 32'd1);
        chk("stall_instr", instruction, 32'h1111_1111);
        tick();
        chk("stall_one_accept", hs - hs_base, 32'd1);
        chk("stall_pc", pc, 32'h8);

        // Load wins over simultaneous fetch_req
        pc_load = 1'b1; pc_next = 32'h0000_0100; fetch_req = 1'b1;
        #1;
        chk("load_no_req_now", {31'd0, mem_req}, 32'd0);
        tick();
        pc_load = 1'b0; fetch_req = 1'b0;
        chk("load_pc", pc, 32'h100);
        chk("load_no_req", {31'd0, mem_req}, 32'd0);
        chk("load_idle", {31'd0, busy}, 32'd0);
        fetch_req = 1'b1; mem_ready = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("load_fetch_addr", mem_addr, 32'h100);
        chk("load_fetch_req", {31'd0, mem_req}, 32'd1);
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
        tick();
        mem_rvalid = 1'b0;
        chk("load_write_ir", {31'd0, write_ir}, 32'd1);
        tick();
        chk("load_pc_inc", pc, 32'h104);

        // Flush in WAIT, response arrives two cycles later
        fetch_req = 1'b1; mem_ready = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        mem_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fw_drain_busy", {31'd0, busy}, 32'd1);
        chk("fw_drain_no_wir", {31'd0, write_ir}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("fw_rvalid_no_wir", {31'd0, write_ir}, 32'd0);
        tick();
        mem_rvalid = 1'b0;
        chk("fw_idle", {31'd0, busy}, 32'd0);
        chk("fw_no_wir", {31'd0, write_ir}, 32'd0);
        chk("fw_instr_kept", instruction, 32'h2222_2222);
        chk("fw_pc_kept", pc, 32'h104);

        // Flush in REQ while not accepted drops mem_req immediately
        fetch_req = 1'b1; mem_ready = 1'b0;
        tick();
        fetch_req = 1'b0;
        chk("fr_req_up", {31'd0, mem_req}, 32'd1);
        flush = 1'b1;
        #1;
        chk("fr_req_dropped", {31'd0, mem_req}, 32'd0);
        tick();
        flush = 1'b0;
        chk("fr_idle", {31'd0, busy}, 32'd0);
        chk("fr_pc_kept", pc, 32'h104);

        // PC wrap at the top of the address space
        pc_load = 1'b1; pc_next = 32'hFFFF_FFFC;
        tick();
        pc_load = 1'b0;
        chk("wrap_loaded", pc, 32'hFFFF_FFFC);
        fetch_req = 1'b1; mem_ready = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h3333_3333;
        tick();
        mem_rvalid = 1'b0;
        chk("wrap_write_ir", {31'd0, write_ir}, 32'd1);
        tick();
        chk("wrap_pc", pc, 32'h0);

        // Misaligned pc
        pc_load = 1'b1; pc_next = 32'h0000_0102;
        tick();
        pc_load = 1'b0;
        fetch_req = 1'b1; mem_ready = 1'b0;
        tick();
        fetch_req = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
        chk("mis_no_req", {31'd0, mem_req}, 32'd0);
        chk("mis_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("mis_fault_pulse", {31'd0, fetch_fault}, 32'd0);
        chk("mis_no_req2", {31'd0, mem_req}, 32'd0);
`else
        chk("mis_req", {31'd0, mem_req}, 32'd1);
        chk("mis_addr", mem_addr, 32'h100);
        chk("mis_no_fault", {31'd0, fetch_fault}, 32'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        mem_rvalid = 1'b0;
        tick();
        chk("mis_pc", pc, 32'h106);
`endif

        // Reset during WAIT, stale response afterwards is ignored
        fetch_req = 1'b1; mem_ready = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        mem_ready = 1'b0; reset = 1'b1;
        #1;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_pc", pc, 32'h0);
        chk("mrst_instr", instruction, 32'h0);
        reset = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h4444_4444;
        tick();
        mem_rvalid = 1'b0;
        chk("stale_busy", {31'd0, busy}, 32'd0);
        chk("stale_no_wir", {31'd0, write_ir}, 32'd0);
        chk("stale_instr", instruction, 32'h0);
        tick();
        chk("stale_pc", pc, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
